// File: rtl/led_fade_4.sv
// ============================================================================
// Module   : led_fade_4
// Brief    : Four-channel PWM fade stage giving chaser LEDs a decaying tail.
//            Optional gamma shaping of the duty cycle: LED_FADE_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fade_4 #(
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 50000,
   parameter int DECAY_STEP = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] led_in,
   output logic [3:0] led_out
);

   localparam int                  c_DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [c_DIV_W-1:0]  c_DIV_MAX  = c_DIV_W'(DECAY_DIV - 1);
   // Step saturated to full range so the truncating cast below stays exact.
   localparam int                  c_STEP_SAT = (DECAY_STEP > 2**PWM_BITS) ? 2**PWM_BITS : DECAY_STEP;
   localparam logic [PWM_BITS:0]   c_STEP     = (PWM_BITS+1)'(c_STEP_SAT);
   localparam logic [PWM_BITS-1:0] c_FULL     = '1;

   logic [3:0]          r_led_in_q;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [c_DIV_W-1:0]  r_decay_cnt;
   logic [3:0]          r_led_out;
   logic [3:0]          w_led_next;
   logic                w_decay_tick;

   assign w_decay_tick = (r_decay_cnt == c_DIV_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led_in_q  <= '0;
         r_pwm_cnt   <= '0;
         r_decay_cnt <= '0;
         r_led_out   <= '0;
      end else begin
         r_led_in_q  <= led_in;
         r_pwm_cnt   <= r_pwm_cnt + 1'b1;
         r_decay_cnt <= w_decay_tick ? '0 : r_decay_cnt + 1'b1;
         r_led_out   <= w_led_next;
      end
   end

   generate
      for (genvar i = 0; i < 4; i++) begin : g_ch
         logic [PWM_BITS-1:0] r_level;
         logic [PWM_BITS-1:0] w_duty;

         // Drive wins over a coincident decay tick.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_level <= '0;
            end else if (r_led_in_q[i]) begin
               r_level <= c_FULL;
            end else if (w_decay_tick) begin
               r_level <= ({1'b0, r_level} > c_STEP) ? (r_level - c_STEP[PWM_BITS-1:0]) : '0;
            end
         end

`ifdef LED_FADE_GAMMA_EN
         logic [2*PWM_BITS-1:0] w_sq;
         assign w_sq   = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
         assign w_duty = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
         assign w_duty = r_level;
`endif

         // Full-scale override avoids a one-cycle dropout per PWM period.
         assign w_led_next[i] = (r_level == c_FULL) | (r_pwm_cnt < w_duty);
      end
   endgenerate

   assign led_out = r_led_out;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_4.sv
// ============================================================================
// Module   : tb_led_fade_4
// Brief    : Directed self-checking bench for led_fade_4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fade_4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] led_in;
   logic [3:0] led_out;

   int n_cmp  = 0;
   int n_fail = 0;
   int e;

   led_fade_4 #(
      .PWM_BITS   (8),
      .DECAY_DIV  (1024),
      .DECAY_STEP (64)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .led_in  (led_in),
      .led_out (led_out)
   );

   always #5 clk = ~clk;

   // Edge index since reset release: after edge k, e == k.
   always @(posedge clk or posedge rst) begin
      if (rst) e <= 0;
      else     e <= e + 1;
   end

`ifdef LED_FADE_GAMMA_EN
   localparam int c_H191 = 142;
   localparam int c_H127 = 63;
   localparam int c_H63  = 15;
`else
   localparam int c_H191 = 191;
   localparam int c_H127 = 127;
   localparam int c_H63  = 63;
`endif

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int k);
      while (e < k) step();
   endtask

   task automatic do_reset(input logic [3:0] pattern_during, input logic [3:0] pattern_after);
      @(negedge clk);
      rst    = 1'b1;
      led_in = pattern_during;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      led_in = pattern_after;
   endtask

   // Counts led_out[0] highs over edges start..start+255 and any activity on [3:1].
   task automatic count_window(input int start, output int highs, output int others);
      highs  = 0;
      others = 0;
      wait_edge(start - 1);
      for (int j = 0; j < 256; j++) begin
         step();
         highs  += int'(led_out[0]);
         others += int'(led_out[3:1] != 3'b000);
      end
   endtask

   task automatic count_bad_until(input int k, input logic [3:0] want, output int bad);
      bad = 0;
      while (e < k) begin
         step();
         bad += int'(led_out !== want);
      end
   endtask

   initial begin
      int bad, hi, oth;
      rst    = 1'b1;
      led_in = 4'b1111;

      // Reset with all inputs high, clock running.
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", int'(led_out), 0);
      do_reset(4'b1111, 4'b0000);
      check("reset_release", int'(led_out), 0);
      count_bad_until(5000, 4'b0000, bad);
      check("reset_quiet_5000", bad, 0);

      // Driven channel and linear/gamma fade.
      do_reset(4'b0000, 4'b0001);
      step();
      check("rise_edge1", int'(led_out), 0);
      step();
      check("rise_edge2", int'(led_out), 0);
      step();
      check("rise_edge3", int'(led_out), 1);
      count_bad_until(1100, 4'b0001, bad);
      check("driven_steady", bad, 0);
      led_in = 4'b0000;
      count_bad_until(2048, 4'b0001, bad);
      check("hold_until_tick", bad, 0);
      count_window(2049, hi, oth);
      check("fade_191", hi, c_H191);
      check("fade_191_others", oth, 0);
      count_window(3073, hi, oth);
      check("fade_127", hi, c_H127);
      count_window(4097, hi, oth);
      check("fade_63", hi, c_H63);
      count_window(5121, hi, oth);
      check("fade_0", hi, 0);
      count_bad_until(6500, 4'b0000, bad);
      check("off_stays_off", bad, 0);

      // Re-assert coincident with a decay tick while level is 127.
      do_reset(4'b0000, 4'b0001);
      wait_edge(500);
      led_in = 4'b0000;
      count_window(2049, hi, oth);
      check("reassert_pre_127", hi, c_H127);
      wait_edge(3070);
      led_in = 4'b0001;
      wait_edge(3072);
      check("reassert_edge3072", int'(led_out), 0);
      count_bad_until(4300, 4'b0001, bad);
      check("reassert_steady", bad, 0);

      // Asynchronous reset in the middle of a fade at level 191.
      do_reset(4'b0000, 4'b0001);
      wait_edge(500);
      led_in = 4'b0000;
      wait_edge(1100);
      check("pre_async_191", int'(led_out), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_clear", int'(led_out), 0);
      #1;
      rst = 1'b0;
      count_bad_until(2500, 4'b0000, bad);
      check("after_async_off", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/led_fade_4.md
# led_fade_4

Four-channel PWM fade stage that sits directly downstream of the 4-LED chaser and drives the board LED pins. Each input bit is the chaser's one-hot LED state. While an input is high, its channel runs at full brightness. When the input drops, the channel dims in fixed steps to off, which gives the running light a trailing "comet" tail. Brightness is produced by a free-running PWM counter compared against a per-channel level register.

## Interface
- `PWM_BITS`, default 8: width of the PWM counter and of each level register; full scale is 2^PWM_BITS-1.
- `DECAY_DIV`, default 50000: clock cycles between decay ticks; must be ≥1.
- `DECAY_STEP`, default 16: amount subtracted from each non-driven level per decay tick; must be ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `led_in`  in  4  chaser LED states; bit i maps to channel i; same clock domain as `clk`.
- `led_out`  out  4  PWM-modulated LED drive; bit i is channel i; registered.

## Operation
- `led_in_q[3:0]`: `led_in` registered once. All channel decisions use `led_in_q`, never raw `led_in`.
- `pwm_cnt[PWM_BITS-1:0]`: free-running counter, +1 every cycle, wraps from all-ones to 0. One PWM period is 2^PWM_BITS cycles.
- `decay_cnt`: counts 0..DECAY_DIV-1 and wraps to 0.
  - `decay_tick` is a 1-cycle internal pulse, asserted when `decay_cnt == DECAY_DIV-1`.
  - With DECAY_DIV=1, `decay_tick` is asserted every cycle.
- `level[i][PWM_BITS-1:0]`, per channel, priority order:
  1. `led_in_q[i]` = 1: level ← all-ones. This holds regardless of `decay_tick`.
  2. Else if `decay_tick`: level ← (level > DECAY_STEP) ? level − DECAY_STEP : 0. Saturating; never wraps below 0.
  3. Else: hold.
- `duty[i]` = level[i] (see Configuration).
- `led_out[i]` ← (level[i] == all-ones) | (pwm_cnt < duty[i]).
  - The full-scale override guarantees a steady 1 while driven, with no 1-cycle gap per period.
  - Level 0 gives a steady 0.
- All four channels share `pwm_cnt` and `decay_tick`; the channels are otherwise independent. Several inputs may be high at once.
- No state machine beyond the counters; each channel is implicitly ON (driven), FADING (0 < level < max, not driven), or OFF (level 0).

## Timing
- Reset (async assert, any time including mid-fade): `led_out` = 0 immediately without a clock edge. `led_in_q`, `pwm_cnt`, `decay_cnt`, and all levels are cleared to 0.
  - Release is synchronous in effect: the first update happens on the first rising edge after `rst` falls.
- Rise latency: `led_in[i]` high sampled at edge n → `led_in_q` at n → level max at n+1 → `led_out[i]` = 1 after edge n+2.
- Fall: `led_in[i]` low sampled at edge n → level holds max until the first `decay_tick` edge after n+1 → `led_out[i]` begins PWM one edge later.
- Fade duration from max to 0: ceil((2^PWM_BITS−1)/DECAY_STEP) decay ticks.
- Re-assert mid-fade: level jumps back to max on the next edge, and any coincident `decay_tick` is ignored for that channel.
- A duty change takes effect on the next cycle, not at the period boundary. Single-cycle glitches at level changes are acceptable.

## Configuration
- `LED_FADE_GAMMA_EN` defined: duty[i] = (level[i]·level[i]) >> PWM_BITS.
  - The product is computed at 2·PWM_BITS width, giving a perceptually linear fade.
  - The full-scale override still applies.
- `LED_FADE_GAMMA_EN` undefined: duty[i] = level[i], giving a linear duty cycle. No multiplier is inferred.

## Test plan
Bench parameters: PWM_BITS=8, DECAY_DIV=1024, DECAY_STEP=64. Each level then lasts 4 full PWM periods.
- Reset: assert `rst` with `led_in`=4'b1111 and a running clock, then release with `led_in`=0 → `led_out` = 4'b0000, and stays 0 for 5000 cycles.
- Driven channel: `led_in`=4'b0001 held → `led_out[0]` goes 1 after the 3rd edge and stays 1 every cycle; `led_out[3:1]`=0 throughout.
- Linear fade (macro undefined): drop `led_in[0]`.
  - Level sequence is 255→191→127→63→0 on successive ticks.
  - High count per aligned 256-cycle period inside each level is 191, 127, 63, then 0.
- Re-assert mid-fade: raise `led_in[0]` while level=127, timed to coincide with `decay_tick` → level=255 next edge, and `led_out[0]` is steady 1 from then on.
- Async reset mid-fade: pulse `rst` between clock edges while level=191 → `led_out` = 0 before the next edge; after release, level is 0 and output stays 0.
- Gamma (`LED_FADE_GAMMA_EN` defined): same fade sequence → high count per period is 142, 63, 15, then 0; level 255 is steady 1.
